// File: rtl/sync_event_bank_if.sv
// -----------------------------------------------------------------------------
// sync_event_bank_if
//   Groups the event-bank signals so the producer/consumer side and the bank
//   itself can each take one bundle.
//
//   Parameters
//     NCH  : number of event channels
//     CNTW : width of a per-channel pending count
//
//   Signals
//     aToggle [NCH]  : toggle lines from foreign clock domains (into the bank)
//     dPulse  [NCH]  : single-cycle event strobes in the bank clock domain
//     evValid        : some channel has a nonzero pending count
//     evChan  [CHW]  : channel currently presented to the consumer
//     evCount [CNTW] : pending count of evChan
//     evAck          : consumer takes the presented channel's count
//     ovf     [NCH]  : sticky overflow flags
//     ovfClr         : clears all overflow flags
//
//   Modports
//     master : the environment side (drives toggles, ack and clear)
//     slave  : the event bank
// -----------------------------------------------------------------------------
interface sync_event_bank_if #(
    parameter int NCH  = 4,
    parameter int CNTW = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]  aToggle;
    logic [NCH-1:0]  dPulse;
    logic            evValid;
    logic [CHW-1:0]  evChan;
    logic [CNTW-1:0] evCount;
    logic            evAck;
    logic [NCH-1:0]  ovf;
    logic            ovfClr;

    modport master (
        output aToggle, evAck, ovfClr,
        input  dPulse, evValid, evChan, evCount, ovf
    );

    modport slave (
        input  aToggle, evAck, ovfClr,
        output dPulse, evValid, evChan, evCount, ovf
    );
endinterface

// File: rtl/sync_event_bank.sv
// -----------------------------------------------------------------------------
// sync_event_bank
//   Brings NCH toggle-encoded event lines from foreign clock domains into the
//   CLK domain, turns every level change into a one-cycle strobe, accumulates
//   strobes in saturating per-channel counters and presents pending channels
//   to a consumer in round-robin order.
//
//   Parameters
//     NCH    : number of channels (1..16)
//     STAGES : synchronizer depth (2..4)
//     CNTW   : pending counter width (1..8)
//     init   : reset level of synchronizer and last-state flops
//
//   Ports
//     CLK : clock, rising edge
//     RST : asynchronous, active-high reset
//     bus : sync_event_bank_if.slave (toggles in, strobes/arbiter/ovf out)
//
//   Build option
//     SYNC_EVENT_OVERFLOW_EN : when defined, sticky per-channel overflow flags
//     are kept; otherwise ovf reads 0, ovfClr is ignored and no flops exist.
// -----------------------------------------------------------------------------
module sync_event_bank #(
    parameter int   NCH    = 4,
    parameter int   STAGES = 2,
    parameter int   CNTW   = 4,
    parameter logic init   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    sync_event_bank_if.slave bus
);
    localparam int              CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CHW-1:0]  LAST_CH = CHW'(NCH - 1);
    localparam logic [CHW:0]    NCH_W   = (CHW + 1)'(NCH);

    // First synchronizer stage: sampled straight from the foreign domain.
    (* ASYNC_REG = "TRUE" *) logic [NCH-1:0] r_sync_p0;
    // Remaining stages 1..STAGES-1; the last one is the settled level.
    logic [NCH-1:0]  r_sync_pn [STAGES-1];
    logic [NCH-1:0]  r_last;
    logic [CNTW-1:0] r_cnt [NCH];
    logic [CHW-1:0]  r_rr;

    logic [NCH-1:0]  w_pulse;
    logic            w_valid;
    logic [CHW-1:0]  w_chan;
    logic [CNTW-1:0] w_count;
    logic [CHW:0]    w_idx;
    logic            w_take;
    logic [CHW-1:0]  w_next;

    // ---- synchronizer and edge detect ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync_p0 <= {NCH{init}};
            for (int s = 0; s < STAGES - 1; s++) begin
                r_sync_pn[s] <= {NCH{init}};
            end
            r_last <= {NCH{init}};
        end else begin
            r_sync_p0    <= bus.aToggle;
            r_sync_pn[0] <= r_sync_p0;
            for (int s = 1; s < STAGES - 1; s++) begin
                r_sync_pn[s] <= r_sync_pn[s-1];
            end
            r_last <= r_sync_pn[STAGES-2];
        end
    end

    assign w_pulse = r_sync_pn[STAGES-2] ^ r_last;

    // ---- round-robin arbiter ----
    // Scan offsets 0..NCH-1 from the pointer; the first nonzero count wins.
    // The index is one bit wider so the wrap works for any NCH.
    always_comb begin
        w_valid = 1'b0;
        w_chan  = '0;
        w_count = '0;
        w_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = {1'b0, r_rr} + (CHW + 1)'(k);
            if (w_idx >= NCH_W) begin
                w_idx = w_idx - NCH_W;
            end
            if (!w_valid && (r_cnt[w_idx[CHW-1:0]] != '0)) begin
                w_valid = 1'b1;
                w_chan  = w_idx[CHW-1:0];
                w_count = r_cnt[w_idx[CHW-1:0]];
            end
        end
    end

    assign w_take = w_valid & bus.evAck;
    assign w_next = (w_chan == LAST_CH) ? '0 : w_chan + 1'b1;

    // ---- pending counters and pointer ----
    // An acked channel restarts from its same-cycle strobe so that strobe
    // is not lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
            r_rr <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_take && (w_chan == CHW'(i))) begin
                    r_cnt[i] <= CNTW'(w_pulse[i]);
                end else if (w_pulse[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            if (w_take) begin
                r_rr <= w_next;
            end
        end
    end

`ifdef SYNC_EVENT_OVERFLOW_EN
    logic [NCH-1:0] r_ovf;
    logic [NCH-1:0] w_ovf_set;

    // A strobe only overflows when it is really dropped: the counter is
    // saturated and not being restarted by an ack in the same cycle.
    always_comb begin
        w_ovf_set = '0;
        for (int i = 0; i < NCH; i++) begin
            w_ovf_set[i] = w_pulse[i] && (r_cnt[i] == CNT_MAX) &&
                           !(w_take && (w_chan == CHW'(i)));
        end
    end

    // ---- overflow flags (set beats clear) ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (bus.ovfClr ? '0 : r_ovf) | w_ovf_set;
        end
    end

    assign bus.ovf = r_ovf;
`else
    logic w_unused_ovfclr;
    assign w_unused_ovfclr = bus.ovfClr;
    assign bus.ovf         = '0;
`endif

    assign bus.dPulse  = w_pulse;
    assign bus.evValid = w_valid;
    assign bus.evChan  = w_chan;
    assign bus.evCount = w_count;

endmodule
